axis_packet_distributor: RTL and testbench

AXIS_PACKET_DISTRIBUTOR -- requirements
Module: axis_packet_distributor

---
 rtl/axis_packet_distributor_pkg.sv | 16 +
 rtl/axis_packet_distributor_rr.sv | 32 +++
 rtl/axis_packet_distributor.sv | 117 +++++++++++
 tb/tb_axis_packet_distributor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_distributor_pkg.sv
// Shared definitions for the axis packet distributor: default beat width,
// index-width helper and the unit-tracking state encoding.
package axis_packet_distributor_pkg;

   localparam int unsigned DEF_AXIS_BYTES = 1;

   typedef enum logic {
      ST_START,
      ST_MID
   } unit_st_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_packet_distributor_rr.sv
// Rotating-priority search: first set bit of req at or after start, wrapping
// from N-1 back to 0.
module axis_rr_pick
   import axis_packet_distributor_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [idx_w(N)-1:0]  start,
   output logic                 found,
   output logic [idx_w(N)-1:0]  idx
);

   localparam int unsigned W = idx_w(N);

   logic [W:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = {1'b0, start} + (W+1)'(i);
         if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
         if (!found && req[pos[W-1:0]]) begin
            found = 1'b1;
            idx   = pos[W-1:0];
         end
      end
   end

endmodule

// File: rtl/axis_packet_distributor.sv
// One-beat holding register that steers an AXI-Stream input to one of N
// outputs, choosing a new destination per packet (or per beat) in rotation.
module axis_packet_distributor
   import axis_packet_distributor_pkg::*;
#(
   parameter int unsigned AXIS_BYTES         = DEF_AXIS_BYTES,
   parameter int unsigned NUM_MASTER_STREAMS = 4,
   parameter int unsigned PACKET_MODE        = 1,
   parameter int unsigned SKIP_NOT_READY     = 0
) (
   input  logic                                         clk,
   input  logic                                         areset,
   output logic                                         axis_i_tready,
   input  logic                                         axis_i_tvalid,
   input  logic                                         axis_i_tlast,
   input  logic [AXIS_BYTES*8-1:0]                      axis_i_tdata,
   input  logic [NUM_MASTER_STREAMS-1:0]                axis_o_tready,
   output logic [NUM_MASTER_STREAMS-1:0]                axis_o_tvalid,
   output logic [NUM_MASTER_STREAMS-1:0]                axis_o_tlast,
   output logic [NUM_MASTER_STREAMS*AXIS_BYTES*8-1:0]   axis_o_tdata,
   input  logic [NUM_MASTER_STREAMS-1:0]                chan_en,
   output logic [$clog2(NUM_MASTER_STREAMS)-1:0]        cur_dest
);

   localparam int unsigned N  = NUM_MASTER_STREAMS;
   localparam int unsigned DW = AXIS_BYTES * 8;
   localparam int unsigned IW = idx_w(N);

   unit_st_e        st_q, st_d;
   logic            full_q, full_d;
   logic [DW-1:0]   data_q, data_d;
   logic            last_q, last_d;
   logic [IW-1:0]   dest_q, dest_d;
   logic [IW-1:0]   last_dest_q, last_dest_d;
   logic            rdy_q;

   logic [IW-1:0]   rot_start;
   logic            rot_found, skip_found;
   logic [IW-1:0]   rot_idx, skip_idx, pick_idx;
   logic            unit_start, drain, accept;

   assign rot_start = (last_dest_q == IW'(N-1)) ? '0 : last_dest_q + 1'b1;

   axis_rr_pick #(.N(N)) u_pick_rot (
      .req   (chan_en),
      .start (rot_start),
      .found (rot_found),
      .idx   (rot_idx)
   );

   axis_rr_pick #(.N(N)) u_pick_skip (
      .req   (chan_en & axis_o_tready),
      .start (rot_start),
      .found (skip_found),
      .idx   (skip_idx)
   );

   assign pick_idx   = (SKIP_NOT_READY != 0 && skip_found) ? skip_idx : rot_idx;
   assign unit_start = (st_q == ST_START);
   assign drain      = full_q && axis_o_tready[dest_q];

   // rdy_q keeps the input closed until the first edge after reset release;
   // a unit start with no enabled output also blocks, mid-packet beats never do.
   assign axis_i_tready = rdy_q && (!full_q || drain) && (!unit_start || rot_found);
   assign accept        = axis_i_tvalid && axis_i_tready;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         st_q        <= ST_START;
         full_q      <= 1'b0;
         data_q      <= '0;
         last_q      <= 1'b0;
         dest_q      <= '0;
         last_dest_q <= IW'(N-1);
         rdy_q       <= 1'b0;
      end else begin
         st_q        <= st_d;
         full_q      <= full_d;
         data_q      <= data_d;
         last_q      <= last_d;
         dest_q      <= dest_d;
         last_dest_q <= last_dest_d;
         rdy_q       <= 1'b1;
      end
   end

   always_comb begin
      st_d        = st_q;
      full_d      = full_q;
      data_d      = data_q;
      last_d      = last_q;
      dest_d      = dest_q;
      last_dest_d = last_dest_q;
      if (accept) begin
         full_d = 1'b1;
         data_d = axis_i_tdata;
         last_d = axis_i_tlast;
         if (unit_start) begin
            dest_d      = pick_idx;
            last_dest_d = pick_idx;
         end
         if (PACKET_MODE != 0) st_d = axis_i_tlast ? ST_START : ST_MID;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   always_comb begin
      axis_o_tvalid = '0;
      if (full_q) axis_o_tvalid[dest_q] = 1'b1;
   end

   assign axis_o_tdata = {N{data_q}};
   assign axis_o_tlast = {N{last_q}};
   assign cur_dest     = dest_q;

endmodule

// File: tb/tb_axis_packet_distributor.sv
// Directed bench for axis_packet_distributor: packet, beat and skip-not-ready
// configurations driven cycle by cycle against hand-computed expectations.
module tb_axis_packet_distributor;

   logic clk = 1'b0;
   logic areset = 1'b1;
   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // packet mode, strict rotation
   logic        p_i_tready, p_i_tvalid, p_i_tlast;
   logic [7:0]  p_i_tdata;
   logic [3:0]  p_o_tready, p_o_tvalid, p_o_tlast, p_chan_en;
   logic [31:0] p_o_tdata;
   logic [1:0]  p_cur_dest;
   // beat mode
   logic        b_i_tready, b_i_tvalid, b_i_tlast;
   logic [7:0]  b_i_tdata;
   logic [3:0]  b_o_tready, b_o_tvalid, b_o_tlast, b_chan_en;
   logic [31:0] b_o_tdata;
   logic [1:0]  b_cur_dest;
   // packet mode, skip not-ready outputs
   logic        s_i_tready, s_i_tvalid, s_i_tlast;
   logic [7:0]  s_i_tdata;
   logic [3:0]  s_o_tready, s_o_tvalid, s_o_tlast, s_chan_en;
   logic [31:0] s_o_tdata;
   logic [1:0]  s_cur_dest;

   axis_packet_distributor #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(4), .PACKET_MODE(1), .SKIP_NOT_READY(0)) u_pkt (
      .clk(clk), .areset(areset),
      .axis_i_tready(p_i_tready), .axis_i_tvalid(p_i_tvalid), .axis_i_tlast(p_i_tlast), .axis_i_tdata(p_i_tdata),
      .axis_o_tready(p_o_tready), .axis_o_tvalid(p_o_tvalid), .axis_o_tlast(p_o_tlast), .axis_o_tdata(p_o_tdata),
      .chan_en(p_chan_en), .cur_dest(p_cur_dest)
   );

   axis_packet_distributor #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(4), .PACKET_MODE(0), .SKIP_NOT_READY(0)) u_beat (
      .clk(clk), .areset(areset),
      .axis_i_tready(b_i_tready), .axis_i_tvalid(b_i_tvalid), .axis_i_tlast(b_i_tlast), .axis_i_tdata(b_i_tdata),
      .axis_o_tready(b_o_tready), .axis_o_tvalid(b_o_tvalid), .axis_o_tlast(b_o_tlast), .axis_o_tdata(b_o_tdata),
      .chan_en(b_chan_en), .cur_dest(b_cur_dest)
   );

   axis_packet_distributor #(.AXIS_BYTES(1), .NUM_MASTER_STREAMS(4), .PACKET_MODE(1), .SKIP_NOT_READY(1)) u_skip (
      .clk(clk), .areset(areset),
      .axis_i_tready(s_i_tready), .axis_i_tvalid(s_i_tvalid), .axis_i_tlast(s_i_tlast), .axis_i_tdata(s_i_tdata),
      .axis_o_tready(s_o_tready), .axis_o_tvalid(s_o_tvalid), .axis_o_tlast(s_o_tlast), .axis_o_tdata(s_o_tdata),
      .chan_en(s_chan_en), .cur_dest(s_cur_dest)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rep(input logic [7:0] d);
      return {d, d, d, d};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      p_i_tvalid = 1'b0; b_i_tvalid = 1'b0; s_i_tvalid = 1'b0;
      areset = 1'b1;
      #1;
      chk("rst_ready",   32'(p_i_tready), 32'h0);
      chk("rst_valid",   32'(p_o_tvalid), 32'h0);
      chk("rst_dest",    32'(p_cur_dest), 32'h0);
      chk("rst_s_valid", 32'(s_o_tvalid), 32'h0);
      cyc();
      cyc();
      areset = 1'b0;
      #1;
      chk("rel_ready", 32'(p_i_tready), 32'h0);
      cyc();
   endtask

   initial begin
      p_i_tvalid = 1'b0; p_i_tlast = 1'b0; p_i_tdata = '0; p_o_tready = '1; p_chan_en = '1;
      b_i_tvalid = 1'b0; b_i_tlast = 1'b0; b_i_tdata = '0; b_o_tready = '1; b_chan_en = '1;
      s_i_tvalid = 1'b0; s_i_tlast = 1'b0; s_i_tdata = '0; s_o_tready = '1; s_chan_en = '1;

      // four back-to-back 3-beat packets -> outputs 0,1,2,3
      do_reset();
      for (int c = 0; c < 14; c++) begin
         if (c < 12) begin
            p_i_tvalid = 1'b1; p_i_tdata = 8'(c); p_i_tlast = (c % 3 == 2);
         end else begin
            p_i_tvalid = 1'b0; p_i_tlast = 1'b0;
         end
         #1;
         if (c >= 1 && c <= 12) begin
            chk("s1_valid", 32'(p_o_tvalid), 32'd1 << ((c - 1) / 3));
            chk("s1_data",  p_o_tdata, rep(8'(c - 1)));
            chk("s1_last",  32'(p_o_tlast), ((c - 1) % 3 == 2) ? 32'hF : 32'h0);
         end else begin
            chk("s1_idle", 32'(p_o_tvalid), 32'h0);
         end
         if (c < 12) chk("s1_ready", 32'(p_i_tready), 32'h1);
         cyc();
      end

      // chan_en 1010 -> 1,3,1,3
      do_reset();
      p_chan_en = 4'b1010;
      for (int c = 0; c < 5; c++) begin
         p_i_tvalid = (c < 4); p_i_tdata = 8'(8'h20 + c); p_i_tlast = 1'b1;
         #1;
         if (c >= 1) begin
            chk("s2_valid", 32'(p_o_tvalid), ((c - 1) % 2 == 0) ? 32'h2 : 32'h8);
            chk("s2_dest",  32'(p_cur_dest), ((c - 1) % 2 == 0) ? 32'h1 : 32'h3);
         end
         cyc();
      end
      p_i_tvalid = 1'b0;

      // beat mode: six beats -> 0,1,2,3,0,1
      do_reset();
      for (int c = 0; c < 7; c++) begin
         b_i_tvalid = (c < 6); b_i_tdata = 8'(8'h30 + c); b_i_tlast = 1'b0;
         #1;
         if (c >= 1) begin
            chk("s3_valid", 32'(b_o_tvalid), 32'd1 << ((c - 1) % 4));
            chk("s3_dest",  32'(b_cur_dest), 32'((c - 1) % 4));
            chk("s3_data",  b_o_tdata, rep(8'(8'h30 + c - 1)));
         end
         cyc();
      end
      b_i_tvalid = 1'b0;

      // skip not-ready: after output 0, output 1 not ready -> output 2
      do_reset();
      s_o_tready = 4'b1111;
      s_i_tvalid = 1'b1; s_i_tdata = 8'hA0; s_i_tlast = 1'b1;
      #1; chk("s4_ready0", 32'(s_i_tready), 32'h1);
      cyc();
      s_i_tdata = 8'hB0; s_o_tready = 4'b1101;
      #1;
      chk("s4_a_valid", 32'(s_o_tvalid), 32'h1);
      chk("s4_ready1",  32'(s_i_tready), 32'h1);
      cyc();
      s_i_tvalid = 1'b0;
      #1;
      chk("s4_skip_valid", 32'(s_o_tvalid), 32'h4);
      chk("s4_skip_data",  s_o_tdata, rep(8'hB0));
      chk("s4_skip_dest",  32'(s_cur_dest), 32'h2);
      cyc();
      #1; chk("s4_idle", 32'(s_o_tvalid), 32'h0);

      // skip not-ready: nothing ready -> falls back to output 1 and waits
      do_reset();
      s_o_tready = 4'b1111;
      s_i_tvalid = 1'b1; s_i_tdata = 8'hC0; s_i_tlast = 1'b1;
      #1; cyc();
      s_i_tvalid = 1'b0;
      #1; chk("s4_c_valid", 32'(s_o_tvalid), 32'h1);
      cyc();
      s_o_tready = 4'b0000; s_i_tvalid = 1'b1; s_i_tdata = 8'hD0;
      #1; chk("s4_d_ready", 32'(s_i_tready), 32'h1);
      cyc();
      s_i_tvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("s4_wait_valid", 32'(s_o_tvalid), 32'h2);
         chk("s4_wait_dest",  32'(s_cur_dest), 32'h1);
         chk("s4_wait_ready", 32'(s_i_tready), 32'h0);
         cyc();
      end
      s_o_tready = 4'b1111;
      #1; chk("s4_d_data", s_o_tdata, rep(8'hD0));
      cyc();
      #1; chk("s4_d_idle", 32'(s_o_tvalid), 32'h0);

      // stall output 2 mid-packet for 5 cycles; chan_en change ignored mid-packet
      do_reset();
      p_chan_en = 4'b0100; p_o_tready = 4'b1111;
      p_i_tvalid = 1'b1; p_i_tdata = 8'h10; p_i_tlast = 1'b0;
      #1; chk("s5_ready0", 32'(p_i_tready), 32'h1);
      cyc();
      p_i_tdata = 8'h11; p_o_tready = 4'b1011; p_chan_en = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("s5_stall_valid", 32'(p_o_tvalid), 32'h4);
         chk("s5_stall_data",  p_o_tdata, rep(8'h10));
         chk("s5_stall_ready", 32'(p_i_tready), 32'h0);
         cyc();
      end
      p_o_tready = 4'b1111;
      #1;
      chk("s5_rel_data",  p_o_tdata, rep(8'h10));
      chk("s5_rel_ready", 32'(p_i_tready), 32'h1);
      cyc();
      p_i_tdata = 8'h12;
      #1;
      chk("s5_b1_valid", 32'(p_o_tvalid), 32'h4);
      chk("s5_b1_data",  p_o_tdata, rep(8'h11));
      cyc();
      p_i_tdata = 8'h13; p_i_tlast = 1'b1;
      #1; chk("s5_b2_data", p_o_tdata, rep(8'h12));
      cyc();
      p_i_tdata = 8'h14;
      #1;
      chk("s5_b3_valid", 32'(p_o_tvalid), 32'h4);
      chk("s5_b3_data",  p_o_tdata, rep(8'h13));
      chk("s5_b3_last",  32'(p_o_tlast), 32'hF);
      cyc();
      p_i_tvalid = 1'b0; p_i_tlast = 1'b0;
      #1;
      chk("s5_next_valid", 32'(p_o_tvalid), 32'h1);
      chk("s5_next_data",  p_o_tdata, rep(8'h14));
      cyc();

      // reset mid-packet, then restart at output 0; chan_en=0 blocks input
      p_chan_en = 4'b1111; p_o_tready = 4'b1111;
      do_reset();
      p_i_tvalid = 1'b1; p_i_tdata = 8'hE0; p_i_tlast = 1'b1;
      #1; cyc();
      p_i_tdata = 8'hE1; p_i_tlast = 1'b0;
      #1; chk("s6_e0_valid", 32'(p_o_tvalid), 32'h1);
      cyc();
      p_i_tdata = 8'hE2;
      #1;
      chk("s6_e1_valid", 32'(p_o_tvalid), 32'h2);
      chk("s6_e1_dest",  32'(p_cur_dest), 32'h1);
      areset = 1'b1;
      #1;
      chk("s6_rst_valid", 32'(p_o_tvalid), 32'h0);
      chk("s6_rst_ready", 32'(p_i_tready), 32'h0);
      chk("s6_rst_dest",  32'(p_cur_dest), 32'h0);
      cyc();
      areset = 1'b0; p_i_tvalid = 1'b0;
      #1; chk("s6_rel_ready", 32'(p_i_tready), 32'h0);
      cyc();
      p_i_tvalid = 1'b1; p_i_tdata = 8'hF0; p_i_tlast = 1'b1;
      #1; chk("s6_f0_ready", 32'(p_i_tready), 32'h1);
      cyc();
      p_i_tvalid = 1'b0;
      #1;
      chk("s6_f0_valid", 32'(p_o_tvalid), 32'h1);
      chk("s6_f0_data",  p_o_tdata, rep(8'hF0));
      cyc();
      p_chan_en = 4'b0000; p_i_tvalid = 1'b1; p_i_tdata = 8'hF1;
      #1; chk("s6_off_ready0", 32'(p_i_tready), 32'h0);
      cyc();
      #1;
      chk("s6_off_ready1", 32'(p_i_tready), 32'h0);
      chk("s6_off_valid",  32'(p_o_tvalid), 32'h0);
      p_chan_en = 4'b0001;
      #1; chk("s6_on_ready", 32'(p_i_tready), 32'h1);
      cyc();
      p_i_tvalid = 1'b0;
      #1;
      chk("s6_on_valid", 32'(p_o_tvalid), 32'h1);
      chk("s6_on_data",  p_o_tdata, rep(8'hF1));
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
